// File: rtl/garo_trng_word.sv
// garo_trng_word: XOR of free-running Galois ring oscillators, synchronised into clk,
// screened by a repetition-count health test, von Neumann debiased and packed into words
// delivered over a valid/ready port with a single word of buffering.
module garo_trng_word #(
    parameter int unsigned       CHANNELS   = 4,
    parameter int unsigned       STAGES     = 31,
    parameter logic [STAGES-1:0] POLY       = 31'h4C6D_B9E1,
    parameter int unsigned       SYNC_DEPTH = 2,
    parameter int unsigned       WORD_W     = 8,
    parameter int unsigned       RCT_LIMIT  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              test_en,
    input  logic              test_bit,
    input  logic              clear_fail,
    input  logic              word_ready,
    output logic              word_valid,
    output logic [WORD_W-1:0] word,
    output logic              health_fail
);

    localparam int unsigned     CntW    = $clog2(WORD_W + 1);
    localparam int unsigned     RctW    = $clog2(RCT_LIMIT + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(WORD_W);
    localparam logic [RctW-1:0] RctMax  = RctW'(RCT_LIMIT);

    // ------------------------------------------------------------------
    // Ring oscillators. The loops are intentional; the attributes stop
    // synthesis from collapsing or pruning the stages.
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] ring_out;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ring
        (* keep = "true", dont_touch = "true" *) logic [STAGES:1] stage;

        assign stage[1] = ~(enable & stage[2]);
        for (genvar i = 2; i < STAGES; i++) begin : g_stage
            assign stage[i] = ~stage[i+1] ^ (POLY[i] & stage[1]);
        end
        assign stage[STAGES] = ~stage[1];
        assign ring_out[c]   = stage[1];
    end

    logic ring_xor;
    assign ring_xor = ^ring_out;

    // ------------------------------------------------------------------
    // Synchroniser with an enable qualifier of matching latency
    // ------------------------------------------------------------------
    logic [SYNC_DEPTH-1:0] sync_q;
    logic [SYNC_DEPTH-1:0] en_q;

    // Metastability chain for the raw ring bit and the aligned enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            en_q   <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], ring_xor};
            en_q   <= {en_q[SYNC_DEPTH-2:0], enable};
        end
    end

    logic raw;
    logic raw_ok;
    assign raw    = test_en ? test_bit : sync_q[SYNC_DEPTH-1];
    assign raw_ok = test_en | en_q[SYNC_DEPTH-1];

    // ------------------------------------------------------------------
    // Health test, debiaser, packer and output buffer state
    // ------------------------------------------------------------------
    logic [RctW-1:0]   rct_q, rct_d, rct_step;
    logic              prev_q, prev_d;
    logic              fail_q, fail_d;
    logic              phase_q, phase_d;
    logic              first_q, first_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              valid_q, valid_d;

    logic sample_en;
    logic fail_set;
    logic accept;
    logic emit;
    logic emit_bit;

    assign sample_en  = raw_ok & ~fail_q;
    assign rct_step   = (raw != prev_q) ? RctW'(1) :
                        (rct_q == RctMax) ? rct_q : rct_q + 1'b1;
    assign fail_set   = sample_en & (rct_step == RctMax);
    // A failed source hides any buffered word from the consumer immediately.
    assign word_valid = valid_q & ~fail_q;
    assign accept     = word_valid & word_ready;

    // Next-state for RCT, debiaser phase, packing and output buffer.
    always_comb begin
        rct_d    = rct_q;
        prev_d   = prev_q;
        fail_d   = fail_q;
        phase_d  = phase_q;
        first_d  = first_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        valid_d  = valid_q;
        emit     = 1'b0;
        emit_bit = 1'b0;

        if (sample_en) begin
            rct_d  = rct_step;
            prev_d = raw;
        end

        // A failure detected on the same edge as clear_fail wins.
        if (fail_set) begin
            fail_d = 1'b1;
        end else if (clear_fail) begin
            fail_d = 1'b0;
        end

        // Losing raw_ok breaks pair continuity, so drop any stored first sample.
        if (!raw_ok) begin
            phase_d = 1'b0;
        end else if (sample_en) begin
            if (!phase_q) begin
                first_d = raw;
                phase_d = 1'b1;
            end else begin
                phase_d  = 1'b0;
                emit     = first_q ^ raw;
                emit_bit = first_q;
            end
        end

        // A full shift register holds its word; later bits are dropped.
        if (emit && (cnt_q != CntFull)) begin
            shift_d = {shift_q[WORD_W-2:0], emit_bit};
            cnt_d   = cnt_q + 1'b1;
        end

        if (fail_q) begin
            valid_d = 1'b0;
        end else begin
            if (accept) begin
                valid_d = 1'b0;
            end
            if ((cnt_d == CntFull) && (!valid_q || accept)) begin
                word_d  = shift_d;
                valid_d = 1'b1;
                cnt_d   = '0;
            end
        end

        if (clear_fail && !fail_set) begin
            rct_d   = '0;
            phase_d = 1'b0;
            cnt_d   = '0;
        end
    end

    // State registers for health test, debiaser, packer and output buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rct_q   <= '0;
            prev_q  <= 1'b0;
            fail_q  <= 1'b0;
            phase_q <= 1'b0;
            first_q <= 1'b0;
            shift_q <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            rct_q   <= rct_d;
            prev_q  <= prev_d;
            fail_q  <= fail_d;
            phase_q <= phase_d;
            first_q <= first_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word        = word_q;
    assign health_fail = fail_q;

endmodule

// File: tb/tb_garo_trng_word.sv
// Testbench for garo_trng_word. The rings are kept stopped (enable = 0) because a
// free-running zero-delay ring cannot settle in simulation; raw bits come from test_bit.
module tb_garo_trng_word;

    localparam int unsigned W     = 8;
    localparam int unsigned LIMIT = 32;
    localparam int unsigned SD    = 2;

    logic         clk        = 1'b0;
    logic         reset      = 1'b0;
    logic         enable     = 1'b0;
    logic         test_en    = 1'b0;
    logic         test_bit   = 1'b0;
    logic         clear_fail = 1'b0;
    logic         word_ready = 1'b0;
    logic         word_valid;
    logic [W-1:0] word;
    logic         health_fail;

    garo_trng_word #(
        .CHANNELS  (4),
        .STAGES    (31),
        .POLY      (31'h4C6D_B9E1),
        .SYNC_DEPTH(SD),
        .WORD_W    (W),
        .RCT_LIMIT (LIMIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .test_en    (test_en),
        .test_bit   (test_bit),
        .clear_fail (clear_fail),
        .word_ready (word_ready),
        .word_valid (word_valid),
        .word       (word),
        .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: run length of identical samples, pending first bit of a pair,
    // queue of collected debiased bits and a one-entry output buffer.
    int           m_run;
    bit           m_last;
    bit           m_fail;
    bit           m_have_first;
    bit           m_first;
    bit           m_bits[$];
    bit           m_valid;
    logic [W-1:0] m_word;

    function automatic void model_reset();
        m_run        = 0;
        m_last       = 1'b0;
        m_fail       = 1'b0;
        m_have_first = 1'b0;
        m_first      = 1'b0;
        m_bits.delete();
        m_valid      = 1'b0;
        m_word       = '0;
    endfunction

    function automatic void model_step(bit ok, bit r, bit rdy, bit clr);
        bit           acc;
        bit           nf;
        bit           got;
        bit           b;
        logic [W-1:0] pw;
        acc = m_valid && rdy;
        nf  = 1'b0;
        got = 1'b0;
        b   = 1'b0;
        if (ok && !m_fail) begin
            m_run  = (r == m_last) ? m_run + 1 : 1;
            m_last = r;
            if (m_run >= LIMIT) nf = 1'b1;
            if (m_have_first) begin
                m_have_first = 1'b0;
                if (m_first != r) begin
                    got = 1'b1;
                    b   = m_first;
                end
            end else begin
                m_have_first = 1'b1;
                m_first      = r;
            end
        end
        if (!ok) m_have_first = 1'b0;
        if (got && m_bits.size() < W) m_bits.push_back(b);
        if (!m_fail) begin
            if (acc) m_valid = 1'b0;
            if (m_bits.size() == W && !m_valid) begin
                pw = '0;
                foreach (m_bits[i]) pw = {pw[W-2:0], m_bits[i]};
                m_word  = pw;
                m_valid = 1'b1;
                m_bits.delete();
            end
        end
        if (nf) begin
            m_fail  = 1'b1;
            m_valid = 1'b0;
        end else if (clr) begin
            m_fail       = 1'b0;
            m_run        = 0;
            m_have_first = 1'b0;
            m_bits.delete();
        end
    endfunction

    // One clock: advance the model with the current inputs, then sample after the edge.
    task automatic step();
        model_step(test_en, test_bit, word_ready, clear_fail);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset      = 1'b1;
        test_en    = 1'b0;
        test_bit   = 1'b0;
        clear_fail = 1'b0;
        word_ready = 1'b0;
    endtask

    // A 1 bit is sent as pair 10 and a 0 bit as pair 01, MSB first.
    task automatic feed_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) begin
            test_bit = w[i];
            step();
            test_bit = ~w[i];
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        #2;
        vectors++;
        if ({word_valid, word, health_fail} !== {1'b0, 8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_initial: got v=%b w=%h f=%b expected v=0 w=00 f=0",
                     word_valid, word, health_fail);
        end
        @(posedge clk);
        #1;
        reset   = 1'b1;
        test_en = 1'b1;
        feed_word(8'hB2);
        vectors++;
        if (word_valid !== 1'b1 || word !== 8'hB2) begin
            miscompares++;
            $display("FAIL reset_preword: got v=%b w=%h expected v=1 w=b2", word_valid, word);
        end
        for (int i = 0; i < 3; i++) begin
            test_bit = i[0];
            step();
            test_bit = ~i[0];
            step();
        end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({word_valid, word, health_fail} !== {1'b0, 8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_async: got v=%b w=%h f=%b expected v=0 w=00 f=0",
                     word_valid, word, health_fail);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        feed_word(8'h5C);
        vectors++;
        if (word_valid !== 1'b1 || word !== 8'h5C) begin
            miscompares++;
            $display("FAIL reset_fresh: got v=%b w=%h expected v=1 w=5c", word_valid, word);
        end
    endtask

    task automatic test_packing();
        logic [W-1:0] w;
        do_reset();
        word_ready = 1'b1;
        test_en    = 1'b1;
        w          = 8'hB2;
        for (int e = 1; e <= 16; e++) begin
            test_bit = ((e % 2) == 1) ? w[W-1-(e-1)/2] : ~w[W-1-(e-1)/2];
            step();
            vectors++;
            if (word_valid !== (e == 16)) begin
                miscompares++;
                $display("FAIL pack_valid edge %0d: got %b expected %b", e, word_valid, e == 16);
            end
        end
        vectors++;
        if (word !== 8'hB2) begin
            miscompares++;
            $display("FAIL pack_word: got %h expected b2", word);
        end
        test_en = 1'b0;
        step();
        vectors++;
        if (word_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL pack_one_cycle: got %b expected 0", word_valid);
        end
    endtask

    task automatic test_discard();
        do_reset();
        word_ready = 1'b1;
        test_en    = 1'b1;
        for (int i = 0; i < 200; i++) begin
            test_bit = (i >> 1) & 1;
            step();
            vectors++;
            if ({word_valid, health_fail} !== 2'b00) begin
                miscompares++;
                $display("FAIL discard cyc %0d: got v=%b f=%b expected v=0 f=0",
                         i, word_valid, health_fail);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        test_en = 1'b1;
        feed_word(8'hB2);
        feed_word(8'h0F);
        feed_word(8'hAA);
        test_en = 1'b0;
        step();
        step();
        vectors++;
        if (word_valid !== 1'b1 || word !== 8'hB2 || word !== m_word) begin
            miscompares++;
            $display("FAIL bp_hold: got v=%b w=%h expected v=1 w=b2", word_valid, word);
        end
        word_ready = 1'b1;
        step();
        vectors++;
        if (word_valid !== 1'b1 || word !== 8'h0F || word !== m_word) begin
            miscompares++;
            $display("FAIL bp_second: got v=%b w=%h expected v=1 w=0f", word_valid, word);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (word_valid !== 1'b0 || word !== 8'h0F) begin
                miscompares++;
                $display("FAIL bp_drained cyc %0d: got v=%b w=%h expected v=0 w=0f",
                         i, word_valid, word);
            end
        end
    endtask

    task automatic test_rct();
        do_reset();
        test_en = 1'b1;
        feed_word(8'h0F);
        test_bit = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            step();
            vectors++;
            if (health_fail !== (e == 32) || word_valid !== (e != 32)) begin
                miscompares++;
                $display("FAIL rct edge %0d: got f=%b v=%b expected f=%b v=%b",
                         e, health_fail, word_valid, e == 32, e != 32);
            end
        end
        for (int i = 0; i < 6; i++) begin
            test_bit = i[0];
            step();
            vectors++;
            if (health_fail !== 1'b1 || word_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rct_sticky cyc %0d: got f=%b v=%b expected f=1 v=0",
                         i, health_fail, word_valid);
            end
        end
        test_en    = 1'b0;
        clear_fail = 1'b1;
        step();
        clear_fail = 1'b0;
        vectors++;
        if (health_fail !== 1'b0 || word_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rct_clear: got f=%b v=%b expected f=0 v=0", health_fail, word_valid);
        end
        word_ready = 1'b1;
        test_en    = 1'b1;
        feed_word(8'h3C);
        vectors++;
        if (word_valid !== 1'b1 || word !== 8'h3C) begin
            miscompares++;
            $display("FAIL rct_recover: got v=%b w=%h expected v=1 w=3c", word_valid, word);
        end
    endtask

    // With rings stopped and test_en low nothing is sampled, so the run of ones
    // straddling the gap must total exactly 32 samples before the failure.
    task automatic test_enable();
        do_reset();
        test_en  = 1'b1;
        test_bit = 1'b1;
        for (int i = 0; i < 20; i++) step();
        test_en = 1'b0;
        for (int i = 0; i < 30; i++) begin
            test_bit = 1'($urandom);
            step();
            vectors++;
            if ({word_valid, health_fail} !== 2'b00) begin
                miscompares++;
                $display("FAIL gate cyc %0d: got v=%b f=%b expected v=0 f=0",
                         i, word_valid, health_fail);
            end
        end
        test_en  = 1'b1;
        test_bit = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step();
            vectors++;
            if (health_fail !== (e == 12)) begin
                miscompares++;
                $display("FAIL gate_rct edge %0d: got %b expected %b", e, health_fail, e == 12);
            end
        end
    endtask

    task automatic test_random();
        int burst;
        do_reset();
        burst = 0;
        for (int i = 0; i < 4000; i++) begin
            test_en    = ($urandom_range(0, 9) != 0);
            word_ready = ($urandom_range(0, 2) != 0);
            clear_fail = ($urandom_range(0, 49) == 0);
            if (burst == 0 && $urandom_range(0, 299) == 0) burst = 40;
            if (burst > 0) begin
                test_bit = 1'b1;
                test_en  = 1'b1;
                burst--;
            end else begin
                test_bit = 1'($urandom);
            end
            step();
            vectors++;
            if (word_valid !== m_valid || word !== m_word || health_fail !== m_fail) begin
                miscompares++;
                $display("FAIL random cyc %0d: got v=%b w=%h f=%b expected v=%b w=%h f=%b",
                         i, word_valid, word, health_fail, m_valid, m_word, m_fail);
            end
        end
    endtask

    initial begin
        test_reset();
        test_packing();
        test_discard();
        test_backpressure();
        test_rct();
        test_enable();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
